// File: rtl/fc_result_writer.sv
// fc_result_writer: requantises the two-lane FC results (ReLU, arithmetic
// shift, signed saturation), packs them into one word and streams the words
// sequentially into the result BRAM. Fixed two-cycle latency from an accepted
// valid to its BRAM write, full throughput.

// One lane: stage 1 registers the ReLU + shift result, stage 2 saturation is
// combinational here and registered by the top when it forms the BRAM word.
module fc_rw_lane #(
  parameter int RES_WIDTH = 32,
  parameter int OUT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [4:0]           shift,
  input  logic                 relu_en,
  input  logic [RES_WIDTH-1:0] x,
  output logic [OUT_WIDTH-1:0] sat
);
  logic signed [RES_WIDTH-1:0] xs, v, s_q;
  logic [RES_WIDTH-OUT_WIDTH-1:0] hi;
  logic pos_ovf, neg_ovf;

  assign xs = signed'(x);
  assign v  = (relu_en && xs[RES_WIDTH-1]) ? '0 : xs;

  // Stage 1: ReLU then sign-preserving floor shift, loaded only on accept
  always_ff @(posedge clk) begin
    if (reset)   s_q <= '0;
    else if (en) s_q <= v >>> shift;
  end

  // Value fits OUT_WIDTH only if every bit above the output sign matches it
  assign hi      = s_q[RES_WIDTH-2:OUT_WIDTH-1];
  assign pos_ovf = !s_q[RES_WIDTH-1] && (|hi);
  assign neg_ovf =  s_q[RES_WIDTH-1] && !(&hi);
  assign sat     = pos_ovf ? {1'b0, {(OUT_WIDTH-1){1'b1}}} :
                   neg_ovf ? {1'b1, {(OUT_WIDTH-1){1'b0}}} :
                   s_q[OUT_WIDTH-1:0];
endmodule

module fc_result_writer #(
  parameter int CNT_BIT   = 31,
  parameter int DWIDTH    = 32,
  parameter int AWIDTH    = 12,
  parameter int RES_WIDTH = 32,
  parameter int OUT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_run,
  input  logic [CNT_BIT-1:0]   i_num_cnt,
  input  logic [4:0]           i_shift,
  input  logic                 i_relu_en,
  input  logic                 i_valid,
  input  logic [RES_WIDTH-1:0] i_result_0,
  input  logic [RES_WIDTH-1:0] i_result_1,
  output logic                 o_idle,
  output logic                 o_run,
  output logic                 o_done,
  output logic                 o_overflow,
  output logic [AWIDTH-1:0]    addr_b3,
  output logic                 ce_b3,
  output logic                 we_b3,
  output logic [DWIDTH-1:0]    d_b3,
  input  logic [DWIDTH-1:0]    q_b3
);
  localparam int NUM_LANES = 2;
  localparam logic [CNT_BIT-1:0] ONE = 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t                              state;
  logic [CNT_BIT-1:0]                  num_cnt, in_cnt, wr_cnt;
  logic [4:0]                          shift;
  logic                                relu_en;
  logic                                v1;
  logic                                accept;
  logic [NUM_LANES-1:0][RES_WIDTH-1:0] res;
  logic [NUM_LANES-1:0][OUT_WIDTH-1:0] sat;
  logic                                unused_q;

  // Read port of the result BRAM is never used by this block
  assign unused_q = ^q_b3;

  assign res[0] = i_result_0;
  assign res[1] = i_result_1;
  assign accept = i_valid && o_run && (in_cnt < num_cnt);

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    fc_rw_lane #(.RES_WIDTH(RES_WIDTH), .OUT_WIDTH(OUT_WIDTH)) u_lane (
      .clk     (clk),
      .reset   (reset),
      .en      (accept),
      .shift   (shift),
      .relu_en (relu_en),
      .x       (res[g]),
      .sat     (sat[g])
    );
  end

  // Control FSM, configuration capture, acceptance and the write stage
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      o_idle     <= 1'b1;
      o_run      <= 1'b0;
      o_done     <= 1'b0;
      o_overflow <= 1'b0;
      num_cnt    <= '0;
      in_cnt     <= '0;
      wr_cnt     <= '0;
      shift      <= '0;
      relu_en    <= 1'b0;
      v1         <= 1'b0;
      ce_b3      <= 1'b0;
      we_b3      <= 1'b0;
      addr_b3    <= '0;
      d_b3       <= '0;
    end else begin
      case (state)
        S_IDLE: if (i_run) begin
          state      <= S_RUN;
          o_idle     <= 1'b0;
          o_run      <= 1'b1;
          num_cnt    <= i_num_cnt;
          shift      <= i_shift;
          relu_en    <= i_relu_en;
          in_cnt     <= '0;
          wr_cnt     <= '0;
          o_overflow <= 1'b0;
        end
        S_RUN: if (num_cnt == '0 || (v1 && (wr_cnt + ONE == num_cnt))) begin
          state  <= S_DONE;
          o_run  <= 1'b0;
          o_done <= 1'b1;
        end
        S_DONE: begin
          state  <= S_IDLE;
          o_done <= 1'b0;
          o_idle <= 1'b1;
        end
        default: begin
          state  <= S_IDLE;
          o_idle <= 1'b1;
          o_run  <= 1'b0;
          o_done <= 1'b0;
        end
      endcase

      // A dropped valid is reported even on the cycle a run is started
      if (i_valid && !accept) o_overflow <= 1'b1;
      if (accept) in_cnt <= in_cnt + ONE;

      v1    <= accept;
      ce_b3 <= v1;
      we_b3 <= v1;
      if (v1) begin
        addr_b3 <= wr_cnt[AWIDTH-1:0];
        d_b3    <= {sat[0], sat[1]};
        wr_cnt  <= wr_cnt + ONE;
      end
    end
  end
endmodule
